// File: rtl/bus_bridge_pkg.sv
// Shared frame constants and request/response payload types for the bus bridge.
package bus_bridge_pkg;

    localparam logic [7:0] BB_CMD_WRITE = 8'h57;
    localparam logic [7:0] BB_CMD_READ  = 8'h52;
    localparam logic [7:0] BB_RSP_WACK  = 8'h41;
    localparam logic [7:0] BB_RSP_RDATA = 8'h44;
    localparam logic [7:0] BB_RSP_NAK   = 8'h4E;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  write_data;
        logic        is_write;
    } bus_bridge_req_t;

    typedef struct packed {
        logic       is_write;
        logic [7:0] read_data;
    } bus_bridge_resp_t;

endpackage

// File: rtl/bus_bridge_frame_tx.sv
// Response serialiser: holds up to two bytes and presents them in order on a
// valid/ready byte handshake, pulsing done as the last byte is taken.
module bus_bridge_frame_tx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_byte0,
    input  logic [7:0] load_byte1,
    input  logic [1:0] load_count,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    output logic       done
);

    logic [7:0] byte_q, byte_d;
    logic [7:0] next_q, next_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        byte_d  = byte_q;
        next_d  = next_q;
        count_d = count_q;
        done    = 1'b0;
        if (load) begin
            byte_d  = load_byte0;
            next_d  = load_byte1;
            count_d = load_count;
        end else if ((count_q != 2'd0) && tx_ready) begin
            count_d = count_q - 2'd1;
            if (count_q == 2'd2) begin
                byte_d = next_q;
            end else begin
                done = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q  <= '0;
            next_q  <= '0;
            count_q <= '0;
        end else begin
            byte_q  <= byte_d;
            next_q  <= next_d;
            count_q <= count_d;
        end
    end

    assign tx_byte  = byte_q;
    assign tx_valid = (count_q != 2'd0);

endmodule

// File: rtl/bus_bridge_frame_decoder.sv
// UART byte-stream front end: assembles request frames, issues one request at a
// time and serialises the response. Optional trailing XOR checksum: BUS_BRIDGE_FRAME_CHECKSUM_EN.
module bus_bridge_frame_decoder
    import bus_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    output logic [7:0]       tx_byte,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             req_valid,
    input  logic             req_ready,
    output bus_bridge_req_t  req_payload,
    input  logic             resp_valid,
    output logic             resp_ready,
    input  bus_bridge_resp_t resp_payload,
    output logic             frame_err,
    output logic             busy
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] D_CMD       = 3'd0;
    localparam logic [2:0] D_ADDR_H    = 3'd1;
    localparam logic [2:0] D_ADDR_L    = 3'd2;
    localparam logic [2:0] D_DATA      = 3'd3;
    localparam logic [2:0] D_ISSUE     = 3'd5;
    localparam logic [2:0] D_WAIT_RESP = 3'd6;
    localparam logic [2:0] D_TX        = 3'd7;
`ifdef BUS_BRIDGE_FRAME_CHECKSUM_EN
    localparam logic [2:0] D_CSUM      = 3'd4;
    localparam logic [2:0] D_FRAME_END = D_CSUM;
`else
    localparam logic [2:0] D_FRAME_END = D_ISSUE;
`endif

    logic [2:0]      state_q, state_d;
    bus_bridge_req_t req_q, req_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            frame_err_q, frame_err_d;
    logic            in_frame;

    logic       tx_load;
    logic [7:0] tx_b0;
    logic [7:0] tx_b1;
    logic [1:0] tx_count;
    logic       tx_done;

`ifdef BUS_BRIDGE_FRAME_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Running XOR restarts on the command byte and folds in each frame byte.
    always_comb begin
        csum_d = csum_q;
        if (rx_valid) begin
            if (state_q == D_CMD) begin
                csum_d = rx_byte;
            end else if (state_q inside {D_ADDR_H, D_ADDR_L, D_DATA}) begin
                csum_d = csum_q ^ rx_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

`ifdef BUS_BRIDGE_FRAME_CHECKSUM_EN
    assign in_frame = state_q inside {D_ADDR_H, D_ADDR_L, D_DATA, D_CSUM};
`else
    assign in_frame = state_q inside {D_ADDR_H, D_ADDR_L, D_DATA};
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        req_d       = req_q;
        timer_d     = '0;
        frame_err_d = 1'b0;
        tx_load     = 1'b0;
        tx_b0       = BB_RSP_WACK;
        tx_b1       = resp_payload.read_data;
        tx_count    = 2'd1;

        // Inter-byte timeout; a byte on the expiry cycle wins because rx_valid gates it.
        if (in_frame && !rx_valid) begin
            if (timer_q == TIMEOUT_LAST) begin
                frame_err_d = 1'b1;
                state_d     = D_CMD;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        case (state_q)
            D_CMD: begin
                if (rx_valid) begin
                    if ((rx_byte == BB_CMD_WRITE) || (rx_byte == BB_CMD_READ)) begin
                        req_d.is_write   = (rx_byte == BB_CMD_WRITE);
                        req_d.write_data = 8'h00;
                        state_d          = D_ADDR_H;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            D_ADDR_H: begin
                if (rx_valid) begin
                    req_d.addr[15:8] = rx_byte;
                    state_d          = D_ADDR_L;
                end
            end
            D_ADDR_L: begin
                if (rx_valid) begin
                    req_d.addr[7:0] = rx_byte;
                    state_d         = req_q.is_write ? D_DATA : D_FRAME_END;
                end
            end
            D_DATA: begin
                if (rx_valid) begin
                    req_d.write_data = rx_byte;
                    state_d          = D_FRAME_END;
                end
            end
`ifdef BUS_BRIDGE_FRAME_CHECKSUM_EN
            D_CSUM: begin
                if (rx_valid) begin
                    if (rx_byte == csum_q) begin
                        state_d = D_ISSUE;
                    end else begin
                        frame_err_d = 1'b1;
                        tx_load     = 1'b1;
                        tx_b0       = BB_RSP_NAK;
                        state_d     = D_TX;
                    end
                end
            end
`endif
            D_ISSUE: begin
                frame_err_d = rx_valid;
                if (req_ready) begin
                    state_d = D_WAIT_RESP;
                end
            end
            D_WAIT_RESP: begin
                frame_err_d = rx_valid;
                if (resp_valid) begin
                    tx_load  = 1'b1;
                    tx_b0    = resp_payload.is_write ? BB_RSP_WACK : BB_RSP_RDATA;
                    tx_count = resp_payload.is_write ? 2'd1 : 2'd2;
                    state_d  = D_TX;
                end
            end
            D_TX: begin
                frame_err_d = rx_valid;
                if (tx_done) begin
                    state_d = D_CMD;
                end
            end
            default: state_d = D_CMD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= D_CMD;
            req_q       <= '0;
            timer_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            timer_q     <= timer_d;
            frame_err_q <= frame_err_d;
        end
    end

    bus_bridge_frame_tx u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tx_load),
        .load_byte0 (tx_b0),
        .load_byte1 (tx_b1),
        .load_count (tx_count),
        .tx_ready   (tx_ready),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .done       (tx_done)
    );

    assign req_valid   = (state_q == D_ISSUE);
    assign req_payload = req_q;
    assign resp_ready  = (state_q == D_WAIT_RESP);
    assign frame_err   = frame_err_q;
    assign busy        = (state_q != D_CMD);

endmodule

// File: tb/tb_bus_bridge_frame_decoder.sv
// Bench for bus_bridge_frame_decoder: directed and randomized frames against a
// frame-level reference model (request fields and expected response bytes).
module tb_bus_bridge_frame_decoder;
    import bus_bridge_pkg::*;

    localparam int TO = 16;

    typedef logic [7:0] byte_q_t[$];

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       rx_byte = 8'h00;
    logic             rx_valid = 1'b0;
    logic [7:0]       tx_byte;
    logic             tx_valid;
    logic             tx_ready = 1'b0;
    logic             req_valid;
    logic             req_ready = 1'b0;
    bus_bridge_req_t  req_payload;
    logic             resp_valid = 1'b0;
    logic             resp_ready;
    bus_bridge_resp_t resp_payload = '0;
    logic             frame_err;
    logic             busy;

    int total = 0;
    int bad = 0;
    int err_count = 0;
    int req_count = 0;
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    bus_bridge_frame_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .tx_byte      (tx_byte),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_payload  (req_payload),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_payload (resp_payload),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    // Mid-cycle monitor: inputs and outputs are settled here for the next edge.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_count++;
        if (req_valid === 1'b1 && req_ready === 1'b1) req_count++;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_q.push_back(tx_byte);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
    endtask

    // Reference framing: command, address, optional data, optional XOR checksum.
    function automatic byte_q_t make_frame(input bit wr, input logic [15:0] a,
                                           input logic [7:0] d, input bit good);
        byte_q_t q;
        logic [7:0] c;
        q.push_back(wr ? 8'h57 : 8'h52);
        q.push_back(a[15:8]);
        q.push_back(a[7:0]);
        if (wr) q.push_back(d);
        c = 8'h00;
        foreach (q[i]) c = c ^ q[i];
`ifdef BUS_BRIDGE_FRAME_CHECKSUM_EN
        q.push_back(good ? c : ~c);
`else
        if (!good) q.push_back(c);
`endif
        return q;
    endfunction

    function automatic byte_q_t make_resp(input bit wr, input logic [7:0] rd);
        byte_q_t q;
        if (wr) begin
            q.push_back(8'h41);
        end else begin
            q.push_back(8'h44);
            q.push_back(rd);
        end
        return q;
    endfunction

    task automatic send_frame(input byte_q_t q, input int gap_max);
        foreach (q[i]) begin
            send_byte(q[i]);
            if (i < q.size() - 1) step(gap_max < 0 ? TO - 1 : $urandom_range(0, gap_max));
        end
    endtask

    // One full transaction; gap_max < 0 places every byte exactly on the timeout edge.
    task automatic do_txn(input bit wr, input logic [15:0] a, input logic [7:0] wd,
                          input logic [7:0] rd, input int gap_max, input bit rand_ready,
                          input int hold_n, input bit poke, input string tag);
        byte_q_t fq;
        byte_q_t eq;
        bus_bridge_req_t exp_req;
        int e0;
        int r0;
        bit ok;
        fq = make_frame(wr, a, wd, 1'b1);
        eq = make_resp(wr, rd);
        exp_req.addr       = a;
        exp_req.write_data = wr ? wd : 8'h00;
        exp_req.is_write   = wr;
        e0 = err_count;
        r0 = req_count;
        tx_q.delete();

        send_frame(fq, gap_max);
        total++;
        if (req_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s req_valid got=%b want=1", tag, req_valid);
        end
        total++;
        if (req_payload !== exp_req) begin
            bad++;
            $display("FAIL %s req_payload got=%h want=%h", tag, req_payload, exp_req);
        end
        if (poke) begin
            send_byte(8'h57);
            total++;
            if (frame_err !== 1'b1 || req_valid !== 1'b1) begin
                bad++;
                $display("FAIL %s drop_in_issue frame_err=%b req_valid=%b want 1/1", tag, frame_err, req_valid);
            end
        end
        repeat ($urandom_range(0, 3)) begin
            step(1);
            total++;
            if (req_valid !== 1'b1 || req_payload !== exp_req) begin
                bad++;
                $display("FAIL %s req_hold valid=%b payload=%h want 1/%h", tag, req_valid, req_payload, exp_req);
            end
        end
        req_ready = 1'b1;
        step(1);
        req_ready = 1'b0;
        total++;
        if (resp_ready !== 1'b1 || req_count != r0 + 1) begin
            bad++;
            $display("FAIL %s req_handshake resp_ready=%b reqs=%0d want 1/%0d", tag, resp_ready, req_count - r0, 1);
        end
        if (poke) begin
            send_byte(8'h52);
            total++;
            if (frame_err !== 1'b1 || resp_ready !== 1'b1) begin
                bad++;
                $display("FAIL %s drop_in_wait frame_err=%b resp_ready=%b want 1/1", tag, frame_err, resp_ready);
            end
        end
        step($urandom_range(0, 3));
        resp_valid   = 1'b1;
        resp_payload = '{is_write: wr, read_data: rd};
        step(1);
        resp_valid   = 1'b0;
        resp_payload = '0;
        total++;
        if (tx_valid !== 1'b1 || tx_byte !== eq[0]) begin
            bad++;
            $display("FAIL %s tx_first valid=%b byte=%h want 1/%h", tag, tx_valid, tx_byte, eq[0]);
        end
        for (int h = 0; h < hold_n; h++) begin
            step(1);
            total++;
            if (tx_valid !== 1'b1 || tx_byte !== eq[0]) begin
                bad++;
                $display("FAIL %s tx_hold cyc=%0d valid=%b byte=%h want 1/%h", tag, h, tx_valid, tx_byte, eq[0]);
            end
        end
        for (int c = 0; c < 200 && tx_q.size() < eq.size(); c++) begin
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step(1);
        end
        tx_ready = 1'b0;
        ok = (tx_q.size() == eq.size());
        if (ok) foreach (eq[i]) if (tx_q[i] !== eq[i]) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s tx_bytes got=%p want=%p", tag, tx_q, eq);
        end
        total++;
        if (busy !== 1'b0 || err_count != e0 + (poke ? 2 : 0)) begin
            bad++;
            $display("FAIL %s end busy=%b errs=%0d want 0/%0d", tag, busy, err_count - e0, poke ? 2 : 0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);
        total++;
        if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset tx_byte got=%h want=00", tx_byte); end
        total++;
        if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset tx_valid got=%b want=0", tx_valid); end
        total++;
        if (req_valid !== 1'b0) begin bad++; $display("FAIL reset req_valid got=%b want=0", req_valid); end
        total++;
        if (req_payload !== '0) begin bad++; $display("FAIL reset req_payload got=%h want=0", req_payload); end
        total++;
        if (resp_ready !== 1'b0) begin bad++; $display("FAIL reset resp_ready got=%b want=0", resp_ready); end
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL reset frame_err got=%b want=0", frame_err); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
    endtask

    task automatic test_write();
        do_txn(1'b1, 16'h1234, 8'hAB, 8'h00, 0, 1'b0, 0, 1'b0, "write");
    endtask

    task automatic test_read();
        do_txn(1'b0, 16'h0010, 8'hEE, 8'h5C, 0, 1'b0, 0, 1'b0, "read");
    endtask

    task automatic test_bad_cmd();
        int e0;
        e0 = err_count;
        send_byte(8'hFF);
        total++;
        if (frame_err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bad_cmd pulse frame_err=%b busy=%b want 1/0", frame_err, busy);
        end
        step(1);
        total++;
        if (frame_err !== 1'b0 || err_count != e0 + 1) begin
            bad++;
            $display("FAIL bad_cmd single frame_err=%b errs=%0d want 0/1", frame_err, err_count - e0);
        end
        do_txn(1'b1, 16'($urandom), 8'($urandom), 8'h00, 2, 1'b0, 0, 1'b0, "after_bad_cmd");
    endtask

    task automatic test_timeout();
        int e0;
        int r0;
        e0 = err_count;
        r0 = req_count;
        send_byte(8'h57);
        send_byte(8'h12);
        step(TO - 1);
        total++;
        if (frame_err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout early frame_err=%b busy=%b want 0/1", frame_err, busy);
        end
        step(1);
        total++;
        if (frame_err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout expire frame_err=%b busy=%b want 1/0", frame_err, busy);
        end
        step(2);
        total++;
        if (req_count != r0 || err_count != e0 + 1) begin
            bad++;
            $display("FAIL timeout counts reqs=%0d errs=%0d want 0/1", req_count - r0, err_count - e0);
        end
        do_txn(1'b1, 16'h1234, 8'hAB, 8'h00, 0, 1'b0, 0, 1'b0, "after_timeout");
        do_txn(1'b1, 16'hBEEF, 8'h3C, 8'h00, -1, 1'b0, 0, 1'b0, "timeout_edge_wr");
        do_txn(1'b0, 16'h8001, 8'h00, 8'hA5, -1, 1'b0, 0, 1'b0, "timeout_edge_rd");
    endtask

    task automatic test_backpressure();
        do_txn(1'b0, 16'h4321, 8'h00, 8'h96, 1, 1'b0, 5, 1'b0, "backpressure");
    endtask

    task automatic test_drop_busy();
        do_txn(1'b1, 16'h0F0F, 8'h11, 8'h00, 1, 1'b1, 1, 1'b1, "drop_busy");
    endtask

    task automatic test_reset_mid();
        send_byte(8'h57);
        send_byte(8'h12);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || req_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid busy=%b req_valid=%b want 0/0", busy, req_valid);
        end
        step(2);
        rst_n = 1'b1;
        step(1);
        do_txn(1'b0, 16'h00FF, 8'h00, 8'h01, 0, 1'b0, 0, 1'b0, "after_reset_mid");
    endtask

`ifdef BUS_BRIDGE_FRAME_CHECKSUM_EN
    task automatic test_checksum();
        byte_q_t fq;
        int e0;
        int r0;
        fq = make_frame(1'b1, 16'h1234, 8'hAB, 1'b0);
        e0 = err_count;
        r0 = req_count;
        tx_q.delete();
        send_frame(fq, 0);
        total++;
        if (frame_err !== 1'b1 || req_valid !== 1'b0 || tx_valid !== 1'b1 || tx_byte !== 8'h4E) begin
            bad++;
            $display("FAIL csum_bad err=%b req_valid=%b tx=%b/%h want 1/0/1/4e", frame_err, req_valid, tx_valid, tx_byte);
        end
        for (int c = 0; c < 50 && tx_q.size() < 1; c++) begin
            tx_ready = 1'($urandom_range(0, 1));
            step(1);
        end
        tx_ready = 1'b0;
        step(1);
        total++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'h4E || req_count != r0 || err_count != e0 + 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL csum_nak tx=%p reqs=%0d errs=%0d busy=%b want [4e]/0/1/0", tx_q, req_count - r0, err_count - e0, busy);
        end
        do_txn(1'b1, 16'h1234, 8'hAB, 8'h00, 0, 1'b0, 0, 1'b0, "csum_good");
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            do_txn(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 8'($urandom),
                   3, 1'b1, $urandom_range(0, 2), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_cmd();
        test_timeout();
        test_backpressure();
        test_drop_busy();
        test_reset_mid();
`ifdef BUS_BRIDGE_FRAME_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
